// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen register-block front end: bus access codes,
// response status codes and the adapter FSM state encoding.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_READ         = 2'b10,
        RGGEN_WRITE        = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        BUSY     = 2'b01,
        RESPONSE = 2'b10
    } rggen_adapter_state_e;

    function automatic logic rggen_is_write(rggen_access access);
        return (access == RGGEN_WRITE) || (access == RGGEN_POSTED_WRITE);
    endfunction

endpackage

// File: rtl/rggen_adapter_timer.sv
// BUSY-phase watchdog for the adapter; only built when RGGEN_ADAPTER_TIMEOUT_EN
// is defined. Expires in the TIMEOUT_CYCLES-th consecutive busy cycle.
`ifdef RGGEN_ADAPTER_TIMEOUT_EN
module rggen_adapter_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    output logic expired
);

    localparam int                WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WIDTH-1:0]  LAST  = WIDTH'(TIMEOUT_CYCLES - 1);

    logic [WIDTH-1:0] count;

    // Held at zero outside BUSY, so every BUSY entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst || !busy) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + WIDTH'(1);
        end
    end

    assign expired = busy && (count == LAST);

endmodule
`endif

// File: rtl/rggen_mux.sv
// One-hot OR multiplexer: each entry is masked by its select bit and the
// results are ORed, so an all-zero select yields zero.
module rggen_mux #(
    parameter int WIDTH   = 1,
    parameter int ENTRIES = 1
) (
    input  logic [ENTRIES-1:0]       select,
    input  logic [WIDTH*ENTRIES-1:0] entries,
    output logic [WIDTH-1:0]         result
);

    always_comb begin
        result = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            result = result | (entries[i*WIDTH+:WIDTH] & {WIDTH{select[i]}});
        end
    end

endmodule

// File: rtl/rggen_adapter_core.sv
// Bus-agnostic register-block front end: range-checks one bus request, broadcasts
// it to all registers and returns one response. Optional RGGEN_ADAPTER_TIMEOUT_EN.
module rggen_adapter_core
    import rggen_rtl_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH       = 8,
    parameter int                     LOCAL_ADDRESS_WIDTH = 8,
    parameter int                     BUS_WIDTH           = 32,
    parameter int                     REGISTERS           = 1,
    parameter bit [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = '0,
    parameter int                     BYTE_SIZE           = 256,
    parameter bit                     ERROR_STATUS        = 1'b0,
    parameter bit [BUS_WIDTH-1:0]     DEFAULT_READ_DATA   = '0,
    parameter int                     TIMEOUT_CYCLES      = 255
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_bus_valid,
    input  rggen_access                        i_bus_access,
    input  logic [ADDRESS_WIDTH-1:0]           i_bus_address,
    input  logic [BUS_WIDTH-1:0]               i_bus_write_data,
    input  logic [BUS_WIDTH-1:0]               i_bus_strobe,
    output logic                               o_bus_ready,
    output rggen_status                        o_bus_status,
    output logic [BUS_WIDTH-1:0]               o_bus_read_data,
    output logic                               o_register_valid,
    output rggen_access                        o_register_access,
    output logic [LOCAL_ADDRESS_WIDTH-1:0]     o_register_address,
    output logic [BUS_WIDTH-1:0]               o_register_write_data,
    output logic [BUS_WIDTH-1:0]               o_register_strobe,
    input  logic [REGISTERS-1:0]               i_register_active,
    input  logic [REGISTERS-1:0]               i_register_ready,
    input  logic [2*REGISTERS-1:0]             i_register_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0]     i_register_read_data,
    output rggen_adapter_state_e               o_state
);

    localparam int          OFFSET_WIDTH   = $clog2(BYTE_SIZE);
    localparam rggen_status ERROR_RESPONSE = ERROR_STATUS ? RGGEN_DECODE_ERROR : RGGEN_OKAY;

    rggen_adapter_state_e state;
    rggen_adapter_state_e state_next;
    logic                 capture;
    logic                 resp_load;
    rggen_status          resp_status;
    logic [BUS_WIDTH-1:0] resp_data;
    logic                 in_range;
    logic                 any_active;
    logic                 selected_ready;
    logic                 timeout_expired;
    logic [1:0]           selected_status;
    logic [BUS_WIDTH-1:0] selected_data;

    // The window is aligned to its size, so comparing the bits above the offset suffices.
    assign in_range       = (i_bus_address >> OFFSET_WIDTH) == (BASE_ADDRESS >> OFFSET_WIDTH);
    assign any_active     = |i_register_active;
    assign selected_ready = |(i_register_active & i_register_ready);

    rggen_mux #(.WIDTH(2), .ENTRIES(REGISTERS)) u_status_mux (
        .select  (i_register_active),
        .entries (i_register_status),
        .result  (selected_status)
    );

    rggen_mux #(.WIDTH(BUS_WIDTH), .ENTRIES(REGISTERS)) u_data_mux (
        .select  (i_register_active),
        .entries (i_register_read_data),
        .result  (selected_data)
    );

`ifdef RGGEN_ADAPTER_TIMEOUT_EN
    rggen_adapter_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (i_clk),
        .rst     (i_rst),
        .busy    (state == BUSY),
        .expired (timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        resp_load   = 1'b0;
        resp_status = RGGEN_OKAY;
        resp_data   = '0;
        case (state)
            IDLE: begin
                if (i_bus_valid) begin
                    capture = 1'b1;
                    if (in_range) begin
                        state_next = BUSY;
                    end else begin
                        state_next  = RESPONSE;
                        resp_load   = 1'b1;
                        resp_status = ERROR_RESPONSE;
                        resp_data   = rggen_is_write(i_bus_access) ? '0 : DEFAULT_READ_DATA;
                    end
                end
            end
            BUSY: begin
                // Ready arriving in the expiry cycle takes priority over the timeout.
                if (!any_active) begin
                    state_next  = RESPONSE;
                    resp_load   = 1'b1;
                    resp_status = ERROR_RESPONSE;
                    resp_data   = rggen_is_write(o_register_access) ? '0 : DEFAULT_READ_DATA;
                end else if (selected_ready) begin
                    state_next  = RESPONSE;
                    resp_load   = 1'b1;
                    resp_status = rggen_status'(selected_status);
                    resp_data   = rggen_is_write(o_register_access) ? '0 : selected_data;
                end else if (timeout_expired) begin
                    state_next  = RESPONSE;
                    resp_load   = 1'b1;
                    resp_status = RGGEN_SLAVE_ERROR;
                    resp_data   = rggen_is_write(o_register_access) ? '0 : DEFAULT_READ_DATA;
                end
            end
            RESPONSE: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_register_access     <= rggen_access'(2'b00);
            o_register_address    <= '0;
            o_register_write_data <= '0;
            o_register_strobe     <= '0;
            o_bus_status          <= RGGEN_OKAY;
            o_bus_read_data       <= '0;
        end else begin
            if (capture) begin
                o_register_access     <= i_bus_access;
                o_register_address    <= i_bus_address[LOCAL_ADDRESS_WIDTH-1:0];
                o_register_write_data <= i_bus_write_data;
                o_register_strobe     <= i_bus_strobe;
            end
            if (resp_load) begin
                o_bus_status    <= resp_status;
                o_bus_read_data <= resp_data;
            end
        end
    end

    assign o_register_valid = (state == BUSY);
    assign o_bus_ready      = (state == RESPONSE);
    assign o_state          = state;

`ifdef RGGEN_ENABLE_SVA
    a_onehot_active: assert property (
        @(posedge i_clk) disable iff (i_rst) (state == BUSY) |-> $onehot0(i_register_active)
    );
`endif

endmodule

// File: tb/tb_rggen_adapter_core.sv
// Directed bench for rggen_adapter_core: two instances differing only in
// ERROR_STATUS share the same stimulus; window is 0x000-0x1FF, three registers.
module tb_rggen_adapter_core;
    import rggen_rtl_pkg::*;

    localparam int             AW   = 16;
    localparam int             LAW  = 9;
    localparam int             BW   = 32;
    localparam int             REGS = 3;
    localparam logic [BW-1:0]  DEFAULT_DATA = 32'hDEAD_BEEF;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 bus_valid;
    rggen_access          bus_access;
    logic [AW-1:0]        bus_address;
    logic [BW-1:0]        bus_write_data;
    logic [BW-1:0]        bus_strobe;
    logic [REGS-1:0]      register_active;
    logic [REGS-1:0]      register_ready;
    logic [2*REGS-1:0]    register_status;
    logic [BW*REGS-1:0]   register_read_data;

    logic                 bus_ready,   bus_ready_b;
    rggen_status          bus_status,  bus_status_b;
    logic [BW-1:0]        bus_read_data, bus_read_data_b;
    logic                 register_valid, register_valid_b;
    rggen_access          register_access, register_access_b;
    logic [LAW-1:0]       register_address, register_address_b;
    logic [BW-1:0]        register_write_data, register_write_data_b;
    logic [BW-1:0]        register_strobe, register_strobe_b;
    rggen_adapter_state_e state, state_b;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    rggen_adapter_core #(
        .ADDRESS_WIDTH(AW), .LOCAL_ADDRESS_WIDTH(LAW), .BUS_WIDTH(BW), .REGISTERS(REGS),
        .BASE_ADDRESS(16'h0000), .BYTE_SIZE(512), .ERROR_STATUS(1'b1),
        .DEFAULT_READ_DATA(DEFAULT_DATA), .TIMEOUT_CYCLES(4)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_bus_valid(bus_valid), .i_bus_access(bus_access),
        .i_bus_address(bus_address), .i_bus_write_data(bus_write_data), .i_bus_strobe(bus_strobe),
        .o_bus_ready(bus_ready), .o_bus_status(bus_status), .o_bus_read_data(bus_read_data),
        .o_register_valid(register_valid), .o_register_access(register_access),
        .o_register_address(register_address), .o_register_write_data(register_write_data),
        .o_register_strobe(register_strobe), .i_register_active(register_active),
        .i_register_ready(register_ready), .i_register_status(register_status),
        .i_register_read_data(register_read_data), .o_state(state)
    );

    rggen_adapter_core #(
        .ADDRESS_WIDTH(AW), .LOCAL_ADDRESS_WIDTH(LAW), .BUS_WIDTH(BW), .REGISTERS(REGS),
        .BASE_ADDRESS(16'h0000), .BYTE_SIZE(512), .ERROR_STATUS(1'b0),
        .DEFAULT_READ_DATA(DEFAULT_DATA), .TIMEOUT_CYCLES(4)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_bus_valid(bus_valid), .i_bus_access(bus_access),
        .i_bus_address(bus_address), .i_bus_write_data(bus_write_data), .i_bus_strobe(bus_strobe),
        .o_bus_ready(bus_ready_b), .o_bus_status(bus_status_b), .o_bus_read_data(bus_read_data_b),
        .o_register_valid(register_valid_b), .o_register_access(register_access_b),
        .o_register_address(register_address_b), .o_register_write_data(register_write_data_b),
        .o_register_strobe(register_strobe_b), .i_register_active(register_active),
        .i_register_ready(register_ready), .i_register_status(register_status),
        .i_register_read_data(register_read_data), .o_state(state_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inactive registers carry junk (DECODE_ERROR status, nonzero data) that the mux must mask.
    task automatic clear_register();
        register_active    = '0;
        register_ready     = '0;
        register_status    = 6'b11_11_11;
        register_read_data = {32'h2222_2222, 32'h1111_1111, 32'h7777_7777};
    endtask

    task automatic drive_register(input int idx, input logic rdy, input rggen_status st,
                                  input logic [BW-1:0] data);
        register_active = REGS'(1) << idx;
        register_ready  = rdy ? register_active : '0;
        register_status[2*idx+:2]   = st;
        register_read_data[BW*idx+:BW] = data;
    endtask

    task automatic request(input rggen_access acc, input logic [AW-1:0] addr,
                           input logic [BW-1:0] wd, input logic [BW-1:0] st);
        bus_valid      = 1'b1;
        bus_access     = acc;
        bus_address    = addr;
        bus_write_data = wd;
        bus_strobe     = st;
    endtask

    task automatic release_bus();
        bus_valid = 1'b0;
        clear_register();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_register();
        request(RGGEN_READ, 16'h0300, 32'h0, 32'h0);
        tick();
        tick();
        checks++; if (state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", state, IDLE); end
        checks++; if (bus_ready !== 1'b0) begin fails++; $display("FAIL reset_bus_ready: got %b expected 0", bus_ready); end
        checks++; if (bus_status !== RGGEN_OKAY) begin fails++; $display("FAIL reset_status: got %0d expected 0", bus_status); end
        checks++; if (bus_read_data !== 32'h0) begin fails++; $display("FAIL reset_read_data: got %h expected 0", bus_read_data); end
        checks++; if (register_valid !== 1'b0) begin fails++; $display("FAIL reset_reg_valid: got %b expected 0", register_valid); end
        checks++; if (register_access !== 2'b00) begin fails++; $display("FAIL reset_reg_access: got %b expected 00", register_access); end
        checks++; if (register_address !== 9'h0) begin fails++; $display("FAIL reset_reg_address: got %h expected 0", register_address); end
        checks++; if (register_write_data !== 32'h0 || register_strobe !== 32'h0) begin
            fails++; $display("FAIL reset_reg_data: got %h/%h expected 0/0", register_write_data, register_strobe);
        end
        release_bus();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_zero_wait();
        request(RGGEN_READ, 16'h0004, 32'h0, 32'h0);
        tick();
        checks++; if (register_valid !== 1'b1) begin fails++; $display("FAIL rd_reg_valid: got %b expected 1", register_valid); end
        checks++; if (register_address !== 9'h004) begin fails++; $display("FAIL rd_reg_address: got %h expected 004", register_address); end
        checks++; if (register_access !== RGGEN_READ) begin fails++; $display("FAIL rd_reg_access: got %b expected 10", register_access); end
        checks++; if (bus_ready !== 1'b0) begin fails++; $display("FAIL rd_early_ready: got %b expected 0", bus_ready); end
        drive_register(1, 1'b1, RGGEN_OKAY, 32'hCAFE_0001);
        tick();
        checks++; if (bus_ready !== 1'b1) begin fails++; $display("FAIL rd_ready: got %b expected 1", bus_ready); end
        checks++; if (bus_status !== RGGEN_OKAY) begin fails++; $display("FAIL rd_status: got %0d expected 0", bus_status); end
        checks++; if (bus_read_data !== 32'hCAFE_0001) begin fails++; $display("FAIL rd_data: got %h expected cafe0001", bus_read_data); end
        checks++; if (register_valid !== 1'b0) begin fails++; $display("FAIL rd_reg_valid_drop: got %b expected 0", register_valid); end
        release_bus();
        tick();
        checks++; if (bus_ready !== 1'b0 || state !== IDLE) begin
            fails++; $display("FAIL rd_one_cycle_ready: got ready=%b state=%0d expected 0/IDLE", bus_ready, state);
        end
    endtask

    task automatic test_read_status();
        request(RGGEN_READ, 16'h0000, 32'h0, 32'h0);
        tick();
        drive_register(0, 1'b1, RGGEN_SLAVE_ERROR, 32'h0BAD_F00D);
        tick();
        checks++; if (bus_ready !== 1'b1 || bus_status !== RGGEN_SLAVE_ERROR) begin
            fails++; $display("FAIL rd_reg_status: got ready=%b status=%0d expected 1/2", bus_ready, bus_status);
        end
        checks++; if (bus_read_data !== 32'h0BAD_F00D) begin fails++; $display("FAIL rd_reg_status_data: got %h expected 0badf00d", bus_read_data); end
        release_bus();
        tick();
    endtask

    task automatic test_write_wait();
        int stable_errors;
        stable_errors = 0;
        request(RGGEN_WRITE, 16'h0008, 32'h1234_5678, 32'h0000_FFFF);
        tick();
        request(RGGEN_WRITE, 16'h0008, 32'h1234_5678, 32'h0000_FFFF);
        for (int i = 0; i < 4; i++) begin
            if (register_valid !== 1'b1 || register_address !== 9'h008 || register_access !== RGGEN_WRITE ||
                register_write_data !== 32'h1234_5678 || register_strobe !== 32'h0000_FFFF || bus_ready !== 1'b0)
                stable_errors++;
            drive_register(2, (i == 3), RGGEN_OKAY, 32'hFFFF_0000);
            tick();
        end
        checks++; if (stable_errors != 0) begin fails++; $display("FAIL wr_fields_stable: got %0d unstable cycles expected 0", stable_errors); end
        checks++; if (bus_ready !== 1'b1) begin fails++; $display("FAIL wr_ready_n5: got %b expected 1", bus_ready); end
        checks++; if (bus_status !== RGGEN_OKAY) begin fails++; $display("FAIL wr_status: got %0d expected 0", bus_status); end
        checks++; if (bus_read_data !== 32'h0) begin fails++; $display("FAIL wr_read_data: got %h expected 0", bus_read_data); end
        release_bus();
        tick();
    endtask

    task automatic test_unmapped();
        request(RGGEN_READ, 16'h01F0, 32'h0, 32'h0);
        tick();
        checks++; if (register_valid !== 1'b1 || register_address !== 9'h1F0) begin
            fails++; $display("FAIL unmap_broadcast: got valid=%b addr=%h expected 1/1f0", register_valid, register_address);
        end
        tick();
        checks++; if (bus_ready !== 1'b1 || bus_status !== RGGEN_DECODE_ERROR) begin
            fails++; $display("FAIL unmap_err1: got ready=%b status=%0d expected 1/3", bus_ready, bus_status);
        end
        checks++; if (bus_read_data !== DEFAULT_DATA) begin fails++; $display("FAIL unmap_data: got %h expected deadbeef", bus_read_data); end
        checks++; if (bus_ready_b !== 1'b1 || bus_status_b !== RGGEN_OKAY || bus_read_data_b !== DEFAULT_DATA) begin
            fails++; $display("FAIL unmap_err0: got ready=%b status=%0d data=%h expected 1/0/deadbeef",
                              bus_ready_b, bus_status_b, bus_read_data_b);
        end
        release_bus();
        tick();
    endtask

    task automatic test_out_of_range();
        logic [AW-1:0] addrs [2];
        addrs[0] = 16'h0200;
        addrs[1] = 16'hFFFC;
        for (int k = 0; k < 2; k++) begin
            request(RGGEN_READ, addrs[k], 32'h0, 32'h0);
            checks++; if (register_valid !== 1'b0) begin fails++; $display("FAIL oor_valid_idle: addr=%h got %b expected 0", addrs[k], register_valid); end
            tick();
            checks++; if (bus_ready !== 1'b1 || register_valid !== 1'b0) begin
                fails++; $display("FAIL oor_ready_n1: addr=%h got ready=%b reg_valid=%b expected 1/0", addrs[k], bus_ready, register_valid);
            end
            checks++; if (bus_status !== RGGEN_DECODE_ERROR || bus_read_data !== DEFAULT_DATA) begin
                fails++; $display("FAIL oor_resp: addr=%h got %0d/%h expected 3/deadbeef", addrs[k], bus_status, bus_read_data);
            end
            checks++; if (bus_status_b !== RGGEN_OKAY) begin fails++; $display("FAIL oor_status_b: got %0d expected 0", bus_status_b); end
            release_bus();
            tick();
            checks++; if (register_valid !== 1'b0 || bus_ready !== 1'b0) begin
                fails++; $display("FAIL oor_after: got valid=%b ready=%b expected 0/0", register_valid, bus_ready);
            end
        end
    endtask

`ifdef RGGEN_ADAPTER_TIMEOUT_EN
    task automatic test_timeout();
        int early;
        for (int pass = 0; pass < 2; pass++) begin
            early = 0;
            request(RGGEN_READ, 16'h0004, 32'h0, 32'h0);
            tick();
            for (int i = 0; i < 4; i++) begin
                if (bus_ready !== 1'b0 || register_valid !== 1'b1) early++;
                drive_register(1, (pass == 1) && (i == 3), RGGEN_OKAY, 32'h5A5A_5A5A);
                tick();
            end
            checks++; if (early != 0) begin fails++; $display("FAIL to_busy_hold: pass=%0d got %0d bad cycles expected 0", pass, early); end
            checks++; if (bus_ready !== 1'b1) begin fails++; $display("FAIL to_ready: pass=%0d got %b expected 1", pass, bus_ready); end
            if (pass == 0) begin
                checks++; if (bus_status !== RGGEN_SLAVE_ERROR || bus_read_data !== DEFAULT_DATA) begin
                    fails++; $display("FAIL to_expire: got %0d/%h expected 2/deadbeef", bus_status, bus_read_data);
                end
            end else begin
                checks++; if (bus_status !== RGGEN_OKAY || bus_read_data !== 32'h5A5A_5A5A) begin
                    fails++; $display("FAIL to_ready_wins: got %0d/%h expected 0/5a5a5a5a", bus_status, bus_read_data);
                end
            end
            release_bus();
            tick();
        end
    endtask
`else
    task automatic test_no_timeout();
        int bad;
        bad = 0;
        request(RGGEN_READ, 16'h000C, 32'h0, 32'h0);
        tick();
        drive_register(0, 1'b0, RGGEN_OKAY, 32'h0F0F_0F0F);
        repeat (300) begin
            if (bus_ready !== 1'b0 || register_valid !== 1'b1) bad++;
            tick();
        end
        checks++; if (bad != 0) begin fails++; $display("FAIL busy_wait: got %0d bad cycles expected 0", bad); end
        drive_register(0, 1'b1, RGGEN_OKAY, 32'h0F0F_0F0F);
        tick();
        checks++; if (bus_ready !== 1'b1 || bus_read_data !== 32'h0F0F_0F0F) begin
            fails++; $display("FAIL busy_wait_done: got ready=%b data=%h expected 1/0f0f0f0f", bus_ready, bus_read_data);
        end
        release_bus();
        tick();
    endtask
`endif

    task automatic test_reset_in_busy();
        request(RGGEN_READ, 16'h0004, 32'h0, 32'h0);
        tick();
        checks++; if (register_valid !== 1'b1) begin fails++; $display("FAIL rib_busy: got %b expected 1", register_valid); end
        drive_register(1, 1'b0, RGGEN_OKAY, 32'hAAAA_5555);
        rst = 1'b1;
        tick();
        checks++; if (state !== IDLE || bus_ready !== 1'b0 || register_valid !== 1'b0) begin
            fails++; $display("FAIL rib_idle: got state=%0d ready=%b valid=%b expected IDLE/0/0", state, bus_ready, register_valid);
        end
        checks++; if (register_address !== 9'h0 || bus_status !== RGGEN_OKAY || bus_read_data !== 32'h0) begin
            fails++; $display("FAIL rib_outputs: got addr=%h status=%0d data=%h expected 0/0/0", register_address, bus_status, bus_read_data);
        end
        rst = 1'b0;
        release_bus();
        tick();
        checks++; if (bus_ready !== 1'b0) begin fails++; $display("FAIL rib_no_resp: got %b expected 0", bus_ready); end
        request(RGGEN_READ, 16'h0008, 32'h0, 32'h0);
        tick();
        drive_register(2, 1'b1, RGGEN_OKAY, 32'h1357_2468);
        tick();
        checks++; if (bus_ready !== 1'b1 || bus_read_data !== 32'h1357_2468) begin
            fails++; $display("FAIL rib_next_req: got ready=%b data=%h expected 1/13572468", bus_ready, bus_read_data);
        end
        release_bus();
        tick();
    endtask

    initial begin
        bus_valid      = 1'b0;
        bus_access     = RGGEN_READ;
        bus_address    = '0;
        bus_write_data = '0;
        bus_strobe     = '0;
        rst            = 1'b1;
        clear_register();
        test_reset();
        test_read_zero_wait();
        test_read_status();
        test_write_wait();
        test_unmapped();
        test_out_of_range();
`ifdef RGGEN_ADAPTER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_in_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
